// File: rtl/sb_rx_deserializer_pkg.sv
// rtl/sb_rx_deserializer_pkg.sv - shared constants and state encoding for the sideband receive path
package sb_rx_deserializer_pkg;

    // Packet width in UI and minimum low-cycle gap between bursts
    localparam int SB_PKT_W  = 64;
    localparam int SB_GAP_UI = 32;

    // Receiver framing states, also used by the TX envelope checker
    typedef enum logic [1:0] {
        SB_RX_IDLE = 2'd0,
        SB_RX_RECV = 2'd1,
        SB_RX_GAP  = 2'd2,
        SB_RX_ERR  = 2'd3
    } sb_rx_state_e;

endpackage

// File: rtl/sb_rx_deserializer_if.sv
// rtl/sb_rx_deserializer_if.sv - packet handshake bundle from the deserializer to the message decoder
interface sb_rx_deserializer_if #(
    parameter int PKT_W = sb_rx_deserializer_pkg::SB_PKT_W
) ();

    logic [PKT_W-1:0] pkt_o;
    logic             pkt_valid_o;
    logic             pkt_ready_i;
    logic             parity_err_o;

    // Producer side drives the packet, consumer side drives ready
    modport master (
        output pkt_o,
        output pkt_valid_o,
        output parity_err_o,
        input  pkt_ready_i
    );

    modport slave (
        input  pkt_o,
        input  pkt_valid_o,
        input  parity_err_o,
        output pkt_ready_i
    );

endinterface

// File: rtl/sb_rx_hold_reg.sv
// rtl/sb_rx_hold_reg.sv - single-entry output holding register with valid/ready and overflow pulse
module sb_rx_hold_reg
    import sb_rx_deserializer_pkg::*;
#(
    parameter int PKT_W = SB_PKT_W
) (
    input  logic             clk_800MHz,
    input  logic             reset,
    input  logic             load_i,
    input  logic [PKT_W-1:0] data_i,
    input  logic             parity_i,
    output logic             overflow_o,
    sb_rx_deserializer_if.master pkt_if
);

    logic [PKT_W-1:0] pkt_q, pkt_d;
    logic             valid_q, valid_d;
    logic             parity_q, parity_d;
    logic             overflow_q, overflow_d;
    logic             drain;

    assign drain = valid_q & pkt_if.pkt_ready_i;

    // Load when empty or being drained this cycle; otherwise drop the new packet and flag it
    always_comb begin
        pkt_d      = pkt_q;
        valid_d    = valid_q;
        parity_d   = parity_q;
        overflow_d = 1'b0;
        if (load_i) begin
            if (!valid_q || drain) begin
                pkt_d    = data_i;
                parity_d = parity_i;
                valid_d  = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    // Holding register state
    always_ff @(posedge clk_800MHz or posedge reset) begin
        if (reset) begin
            pkt_q      <= '0;
            valid_q    <= 1'b0;
            parity_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pkt_q      <= pkt_d;
            valid_q    <= valid_d;
            parity_q   <= parity_d;
            overflow_q <= overflow_d;
        end
    end

    assign pkt_if.pkt_o        = pkt_q;
    assign pkt_if.pkt_valid_o  = valid_q;
    assign pkt_if.parity_err_o = parity_q;
    assign overflow_o          = overflow_q;

endmodule

// File: rtl/sb_rx_deserializer.sv
// rtl/sb_rx_deserializer.sv - sideband serial burst receiver with framing and parity checks
module sb_rx_deserializer
    import sb_rx_deserializer_pkg::*;
#(
    parameter int PKT_W  = SB_PKT_W,
    parameter int GAP_UI = SB_GAP_UI
) (
    input  logic clk_800MHz,
    input  logic reset,
    input  logic enable_i,
    input  logic SB_clkPin_RX_i,
    input  logic SB_dataPin_RX_i,
    output logic frame_err_o,
    output logic overflow_o,
    sb_rx_deserializer_if.master pkt_if
);

    localparam int BC_W = $clog2(PKT_W + 1);
    localparam int GC_W = $clog2(GAP_UI + 1);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(PKT_W);
    localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);
    localparam logic [GC_W-1:0] GC_FULL = GC_W'(GAP_UI);
    localparam logic [GC_W-1:0] GC_ONE  = GC_W'(1);

    sb_rx_state_e     state_q, state_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [GC_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [PKT_W-1:0] sreg_q, sreg_d;
    logic             frame_err_q, frame_err_d;
    logic             complete;
    logic [PKT_W-1:0] data_bit;

    // Current UI placed at bit 0, shifted to its slot by bit_cnt during RECV
    assign data_bit = {{(PKT_W-1){1'b0}}, SB_dataPin_RX_i};

    // Framing FSM: next state, bit/gap counters, shift register and error pulse
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        sreg_d      = sreg_q;
        frame_err_d = 1'b0;
        complete    = 1'b0;
        if (!enable_i) begin
            // Disabled link aborts silently and must re-earn a full gap
            state_d   = SB_RX_GAP;
            gap_cnt_d = '0;
            bit_cnt_d = '0;
            sreg_d    = '0;
        end else begin
            case (state_q)
                SB_RX_IDLE: begin
                    if (SB_clkPin_RX_i) begin
                        sreg_d    = data_bit;
                        bit_cnt_d = BC_ONE;
                        state_d   = SB_RX_RECV;
                    end
                end
                SB_RX_RECV: begin
                    if (SB_clkPin_RX_i) begin
                        if (bit_cnt_q == BC_FULL) begin
                            // 65th UI: burst too long
                            frame_err_d = 1'b1;
                            bit_cnt_d   = '0;
                            state_d     = SB_RX_ERR;
                        end else begin
                            sreg_d    = sreg_q | (data_bit << bit_cnt_q);
                            bit_cnt_d = bit_cnt_q + BC_ONE;
                        end
                    end else begin
                        // This low cycle is the first of the following gap
                        complete    = (bit_cnt_q == BC_FULL);
                        frame_err_d = (bit_cnt_q != BC_FULL);
                        bit_cnt_d   = '0;
                        gap_cnt_d   = GC_ONE;
                        state_d     = SB_RX_GAP;
                    end
                end
                SB_RX_GAP: begin
                    if (SB_clkPin_RX_i) begin
                        frame_err_d = 1'b1;
                        state_d     = SB_RX_ERR;
                    end else begin
                        gap_cnt_d = (gap_cnt_q == GC_FULL) ? GC_FULL : gap_cnt_q + GC_ONE;
                        if (gap_cnt_d == GC_FULL) begin
                            state_d = SB_RX_IDLE;
                        end
                    end
                end
                SB_RX_ERR: begin
                    if (!SB_clkPin_RX_i) begin
                        gap_cnt_d = GC_ONE;
                        state_d   = SB_RX_GAP;
                    end
                end
                default: state_d = SB_RX_GAP;
            endcase
        end
    end

    // FSM state register; reset demands a full gap before the first burst
    always_ff @(posedge clk_800MHz or posedge reset) begin
        if (reset) begin
            state_q     <= SB_RX_GAP;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            sreg_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            sreg_q      <= sreg_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err_o = frame_err_q;

    sb_rx_hold_reg #(
        .PKT_W(PKT_W)
    ) u_hold (
        .clk_800MHz (clk_800MHz),
        .reset      (reset),
        .load_i     (complete),
        .data_i     (sreg_q),
        .parity_i   (^sreg_q),
        .overflow_o (overflow_o),
        .pkt_if     (pkt_if)
    );

endmodule

// File: tb/tb_sb_rx_deserializer.sv
// tb/tb_sb_rx_deserializer.sv - scoreboard bench for the sideband receive deserializer
`timescale 1ns/1ps
module tb_sb_rx_deserializer;

    localparam int PW  = 64;
    localparam int GAP = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable_i = 1'b0;
    logic clk_pin = 1'b0;
    logic data_pin = 1'b0;
    logic frame_err_o;
    logic overflow_o;

    sb_rx_deserializer_if #(.PKT_W(PW)) pkt_if ();

    sb_rx_deserializer #(.PKT_W(PW), .GAP_UI(GAP)) dut (
        .clk_800MHz      (clk),
        .reset           (reset),
        .enable_i        (enable_i),
        .SB_clkPin_RX_i  (clk_pin),
        .SB_dataPin_RX_i (data_pin),
        .frame_err_o     (frame_err_o),
        .overflow_o      (overflow_o),
        .pkt_if          (pkt_if.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Link-level reference: lows since last UI, current burst length and legality
    logic [63:0] exp_q[$];
    int          low_run = 0;
    int          cur_len = 0;
    bit          cur_ok = 1'b0;
    logic [63:0] cur_data = '0;
    bit          comp_flag = 1'b0;
    bit          en_v = 1'b1;
    int          exp_ferr = 0;
    int          got_ferr = 0;
    int          exp_ovf = 0;
    int          got_ovf = 0;

    // Consumer-side reference: one-slot holding model
    bit          mon_on = 1'b0;
    int          ready_mode = 2;
    bit          ready_v = 1'b1;
    bit          m_valid = 1'b0;
    logic [63:0] m_pkt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One UI slot on the link; the model decides legality from the line history alone
    task automatic drive(input bit pin, input bit d);
        @(posedge clk);
        #1;
        enable_i  = en_v;
        clk_pin   = pin;
        data_pin  = d;
        comp_flag = 1'b0;
        if (!en_v) begin
            low_run = 0;
            cur_len = 0;
        end else if (pin) begin
            if (cur_len == 0) begin
                cur_ok   = (low_run >= GAP);
                cur_data = '0;
                if (!cur_ok) exp_ferr++;
            end
            if (cur_len < PW) cur_data = cur_data | (64'(d) << cur_len);
            cur_len++;
            if (cur_ok && cur_len == PW + 1) exp_ferr++;
            low_run = 0;
        end else begin
            if (cur_len > 0 && cur_ok) begin
                if (cur_len == PW) begin
                    exp_q.push_back(cur_data);
                    comp_flag = 1'b1;
                end else if (cur_len < PW) begin
                    exp_ferr++;
                end
            end
            cur_len = 0;
            low_run++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    task automatic burst(input logic [64:0] bits, input int len);
        for (int i = 0; i < len; i++) drive(1'b1, bits[i]);
    endtask

    function automatic logic [64:0] rnd65();
        return 65'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic checkpoint(input string tag);
        check({tag, "_frame_err_count"}, 64'(got_ferr), 64'(exp_ferr));
        check({tag, "_overflow_count"}, 64'(got_ovf), 64'(exp_ovf));
    endtask

    // Monitor: compare held packet every cycle, then advance the model with this cycle's events
    always @(negedge clk) begin
        if (mon_on) begin
            logic [63:0] d;
            bit hs;
            check("pkt_valid", 64'(pkt_if.pkt_valid_o), 64'(m_valid));
            if (m_valid) begin
                check("pkt", pkt_if.pkt_o, m_pkt);
                check("parity_err", 64'(pkt_if.parity_err_o), 64'($countones(m_pkt) % 2));
            end
            if (frame_err_o) got_ferr++;
            if (overflow_o) got_ovf++;
            case (ready_mode)
                0:       ready_v = ($urandom_range(0, 9) < 7);
                1:       ready_v = 1'b0;
                default: ready_v = 1'b1;
            endcase
            pkt_if.pkt_ready_i = ready_v;
            hs = m_valid && ready_v;
            if (comp_flag && exp_q.size() > 0) begin
                d = exp_q.pop_front();
                if (!m_valid || hs) begin
                    m_valid = 1'b1;
                    m_pkt   = d;
                end else begin
                    exp_ovf++;
                end
            end else if (hs) begin
                m_valid = 1'b0;
            end
        end
    end

    initial begin
        pkt_if.pkt_ready_i = 1'b1;
        #1;
        check("reset_pkt_valid", 64'(pkt_if.pkt_valid_o), 64'd0);
        check("reset_pkt", pkt_if.pkt_o, 64'd0);
        check("reset_parity_err", 64'(pkt_if.parity_err_o), 64'd0);
        check("reset_frame_err", 64'(frame_err_o), 64'd0);
        check("reset_overflow", 64'(overflow_o), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_on = 1'b1;
        #1;
        reset = 1'b0;

        // Legal burst after the mandatory gap, even parity
        idle(GAP);
        burst({1'b0, 64'h0000_0000_0000_0003}, PW);
        idle(GAP);
        // Held for 10 cycles, released by ready
        ready_mode = 1;
        burst({1'b0, 64'h8000_0000_0000_0001}, PW);
        idle(10);
        ready_mode = 2;
        idle(GAP);
        // Odd parity
        burst({1'b0, 64'h0000_0000_0000_0001}, PW);
        idle(GAP);
        checkpoint("basic");

        // Short and long bursts, then recovery
        burst(rnd65(), 40);
        idle(GAP);
        burst(rnd65(), 65);
        idle(GAP);
        burst(rnd65(), PW);
        idle(GAP);
        checkpoint("length");

        // Gap too short, then exactly the minimum
        burst(rnd65(), PW);
        idle(20);
        burst(rnd65(), PW);
        idle(GAP);
        burst(rnd65(), PW);
        idle(GAP);
        burst(rnd65(), PW);
        idle(GAP);
        checkpoint("gap");

        // Overflow while held
        ready_mode = 1;
        burst(rnd65(), PW);
        idle(GAP);
        burst(rnd65(), PW);
        idle(5);
        ready_mode = 2;
        idle(GAP);
        checkpoint("overflow");

        // Disable mid-burst: silent abort, fresh gap required
        burst(rnd65(), 30);
        en_v = 1'b0;
        idle(3);
        en_v = 1'b1;
        idle(GAP);
        burst(rnd65(), PW);
        idle(GAP);
        checkpoint("enable");

        // Randomized link traffic with random consumer backpressure
        ready_mode = 0;
        for (int n = 0; n < 60; n++) begin
            int g;
            int r;
            int len;
            g = $urandom_range(0, 40);
            if ($urandom_range(0, 3) != 0) g = GAP + $urandom_range(0, 8);
            r = $urandom_range(0, 5);
            len = (r == 0) ? 40 : (r == 1) ? 65 : (r == 2) ? 63 : PW;
            idle(g);
            burst(rnd65(), len);
        end
        ready_mode = 2;
        idle(GAP + 8);
        checkpoint("random");

        // Asynchronous reset in the middle of a burst with a packet held
        ready_mode = 1;
        burst(rnd65(), PW);
        idle(5);
        burst(rnd65(), 10);
        mon_on = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midreset_pkt_valid", 64'(pkt_if.pkt_valid_o), 64'd0);
        check("midreset_pkt", pkt_if.pkt_o, 64'd0);
        check("midreset_parity_err", 64'(pkt_if.parity_err_o), 64'd0);
        check("midreset_frame_err", 64'(frame_err_o), 64'd0);
        check("midreset_overflow", 64'(overflow_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
